mrfm_iq_avg: RTL and testbench
==============================

Name: mrfm_iq_avg

Overview:
- Boxcar averaging decimator between the MRFM processing chain's I/Q outputs (i, q, ip, qp plus sample strobe) and the RX USB buffer.
- Sums 2^k consecutive strobed samples per channel, then emits one rounded mean per channel with a single-cycle output strobe.
- Lowers the USB data rate for long MRFM integrations.
- Length is set via the serial settings bus.

Parameters:
- FR_ADDR, 7'd70, serial_addr of the averaging-length setting register.
- MAX_LOG2, 8, largest k accepted; larger written values clamp to MAX_LOG2.

Ports:
- clock  in  1  system clock (clk64 domain)
- reset  in  1  synchronous, active-high; clears all state and outputs
- enable  in  1  0 = hold in IDLE, discard input samples
- serial_addr  in  7  settings bus address
- serial_data  in  32  settings bus data
- serial_strobe  in  1  settings bus write strobe
- strobe_in  in  1  input sample valid, one-cycle pulse
- i_in, q_in, ip_in, qp_in  in  16 each  signed two's-complement samples
- i_out, q_out, ip_out, qp_out  out  16 each  signed averaged samples
- strobe_out  out  1  output valid, one-cycle pulse
- debugbus  out  16  debug word; see Optional Feature

Behaviour:
- Setting register (write when serial_strobe && serial_addr==FR_ADDR):
  - log2_len = min(serial_data[3:0], MAX_LOG2).
  - N = 2^log2_len.
  - Reset value is 0, so N=1.
- Accumulators:
  - Four signed accumulators, 16+MAX_LOG2+1 = 25 bits each.
  - Inputs are sign-extended before adding.
- Sample counter: cnt, 0..N-1.
- State machine:
  - States: IDLE, ACCUM, DUMP.
  - IDLE -> ACCUM when enable=1. Entering ACCUM sets cnt=0.
  - ACCUM, on strobe_in:
    - if cnt==0: acc = x; otherwise acc = acc + x.
    - if cnt==N-1: go to DUMP and set cnt=0; otherwise cnt = cnt+1.
  - DUMP lasts exactly one cycle. On that edge:
    - out = (acc + (k>0 ? 2^(k-1) : 0)) >>> k, arithmetic shift, k = log2_len.
    - The result fits in 16 bits without saturation, including the all-+32767 and all-−32768 cases.
    - strobe_out = 1 for this cycle only.
  - DUMP -> ACCUM. A strobe_in coincident with DUMP is taken as the first sample of the next frame and is not dropped.
    - Output computation uses the pre-edge acc value.
    - When N=1 this sample is also the last of its frame, so the state stays in DUMP.
- Latency: strobe_out asserts 2 clocks after the clock edge that captures the last strobe_in of a frame. Outputs are registered.
- Throughput: N=1 with strobe_in high every cycle gives strobe_out high every cycle, output equal to input delayed 2 clocks.
- Setting write:
  - Any write to FR_ADDR aborts the current frame: cnt=0, state -> ACCUM (or IDLE if enable=0).
  - A strobe_in on the same cycle as the write is discarded.
  - If the write falls on a DUMP cycle, that DUMP still completes.
- enable falling: state -> IDLE on the next edge, partial frame discarded, outputs hold their last values. strobe_out is 0 in IDLE.
- reset, including mid-frame:
  - Next edge: state=IDLE, cnt=0, acc=0, log2_len=0.
  - All *_out = 0, strobe_out = 0, debugbus = 0.
- Outputs hold between strobe_out pulses.

Optional Feature:
- Macro: MRFM_IQ_AVG_DEBUG_EN.
- Defined: debugbus = {state[1:0], strobe_out, log2_len[3:0], frame_cnt[8:0]}.
  - frame_cnt is a 9-bit wrapping count of strobe_out pulses, cleared by reset.
- Undefined: debugbus tied to 16'd0; frame_cnt logic is not built.

Test Plan:
- Reset default:
  - Stimulus: reset, enable=1, strobe_in on 3 consecutive cycles with i_in=100, 200, −5.
  - Required: strobe_out pulses 2 clocks after each; i_out = 100, 200, −5.
- N=4 rounding:
  - Stimulus: write 4'd2 to FR_ADDR; i_in = 1, 2, 3, 4 (sum 10) on strobes spaced 3 clocks apart.
  - Required: single strobe_out; i_out = (10+2)>>2 = 3.
  - Repeat with q_in = −1, −2, −3, −4: required q_out = (−10+2)>>>2 = −2.
- Extremes at N=256:
  - Stimulus: write 8; 256 samples of +32767 on all channels, then 256 samples of −32768.
  - Required: outputs 32767, then −32768, with no wrap.
- Clamp and abort:
  - Stimulus: write 15; required log2_len=8 (check via debugbus when the macro is enabled).
  - Stimulus: write 1 after 2 of 4 samples at N=4, with a strobe_in coincident with the write.
  - Required: that sample is dropped; the next 2 samples (6, 8) give i_out=7.
- Back-to-back at the frame boundary:
  - Stimulus: N=2, strobe_in high every cycle, i_in = 10, 20, 30, 40.
  - Required: strobe_out pulses 2 clocks apart; i_out = 15, 35; no sample lost.
- Reset and enable mid-frame:
  - Stimulus: N=4, 3 samples, then reset asserted for 1 cycle.
  - Required: all outputs 0, no strobe_out, next full frame averages correctly.
  - Stimulus: enable dropped mid-frame.
  - Required: no strobe_out; last outputs held.

Source files
------------

// File: rtl/mrfm_iq_avg.sv
// mrfm_iq_avg: boxcar averaging decimator for the MRFM I/Q chain.
// Sums 2^k strobed samples on four channels (i, q, ip, qp) and emits
// one rounded mean per channel with a single-cycle strobe_out.
//
// Ports:
//   clock, reset            clk64 domain, synchronous active-high reset
//   enable                  0 holds the block idle and drops samples
//   serial_addr/data/strobe settings bus; FR_ADDR holds log2 length
//   strobe_in, *_in         input sample valid and signed samples
//   strobe_out, *_out       averaged samples, valid for one cycle
//   debugbus                status word when MRFM_IQ_AVG_DEBUG_EN is
//                           defined, otherwise tied to zero
//
// Optional feature macro: MRFM_IQ_AVG_DEBUG_EN
module mrfm_iq_avg #(
    parameter logic [6:0] FR_ADDR  = 7'd70,
    parameter int         MAX_LOG2 = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [6:0]         serial_addr,
    input  logic [31:0]        serial_data,
    input  logic               serial_strobe,
    input  logic               strobe_in,
    input  logic signed [15:0] i_in,
    input  logic signed [15:0] q_in,
    input  logic signed [15:0] ip_in,
    input  logic signed [15:0] qp_in,
    output logic signed [15:0] i_out,
    output logic signed [15:0] q_out,
    output logic signed [15:0] ip_out,
    output logic signed [15:0] qp_out,
    output logic               strobe_out,
    output logic [15:0]        debugbus
);

    localparam int AW = 16 + MAX_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DUMP  = 2'd2
    } state_t;

    state_t                    state;
    logic [3:0]                log2_len;
    logic [MAX_LOG2-1:0]       cnt;
    logic [MAX_LOG2-1:0]       last_idx;
    logic signed [AW-1:0]      acc     [4];
    logic signed [AW-1:0]      avg     [4];
    logic signed [AW-1:0]      rnd;
    logic signed [15:0]        x       [4];
    logic signed [15:0]        out_r   [4];
    logic                      wr;
    logic [3:0]                k_new;

    assign x[0] = i_in;
    assign x[1] = q_in;
    assign x[2] = ip_in;
    assign x[3] = qp_in;

    assign i_out  = out_r[0];
    assign q_out  = out_r[1];
    assign ip_out = out_r[2];
    assign qp_out = out_r[3];

    assign wr = serial_strobe && (serial_addr == FR_ADDR);

    assign k_new = (serial_data[3:0] > 4'(MAX_LOG2)) ?
                   4'(MAX_LOG2) : serial_data[3:0];

    // Index of the last sample in a frame: low k bits set.
    assign last_idx = ~({MAX_LOG2{1'b1}} << log2_len);

    // Half an LSB of the output for round-half-up.
    assign rnd = (log2_len == 4'd0) ? '0 :
                 AW'(1) << (log2_len - 4'd1);

    // The accumulator carries one guard bit, so even the extreme
    // full-scale frames round back into 16 bits without saturating.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            avg[c] = (acc[c] + rnd) >>> log2_len;
        end
    end

`ifdef MRFM_IQ_AVG_DEBUG_EN
    logic [8:0] frame_cnt;
    assign debugbus = {state, strobe_out, log2_len, frame_cnt};
`else
    assign debugbus = 16'd0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            log2_len   <= 4'd0;
            cnt        <= '0;
            strobe_out <= 1'b0;
            for (int c = 0; c < 4; c++) begin
                acc[c]   <= '0;
                out_r[c] <= '0;
            end
`ifdef MRFM_IQ_AVG_DEBUG_EN
            frame_cnt  <= 9'd0;
`endif
        end else begin
            strobe_out <= 1'b0;

            if (wr) begin
                log2_len <= k_new;
            end

            // A completed frame is always emitted, even if this cycle
            // also carries a settings write or enable has just dropped.
            if (state == DUMP) begin
                strobe_out <= 1'b1;
                for (int c = 0; c < 4; c++) begin
                    out_r[c] <= avg[c][15:0];
                end
`ifdef MRFM_IQ_AVG_DEBUG_EN
                frame_cnt <= frame_cnt + 9'd1;
`endif
            end

            if (wr) begin
                cnt   <= '0;
                state <= enable ? ACCUM : IDLE;
            end else if (!enable) begin
                cnt   <= '0;
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        cnt   <= '0;
                        state <= ACCUM;
                    end
                    ACCUM, DUMP: begin
                        state <= ACCUM;
                        if (strobe_in) begin
                            for (int c = 0; c < 4; c++) begin
                                if (cnt == '0) begin
                                    acc[c] <= {{(AW-16){x[c][15]}}, x[c]};
                                end else begin
                                    acc[c] <= acc[c] +
                                        {{(AW-16){x[c][15]}}, x[c]};
                                end
                            end
                            if (cnt == last_idx) begin
                                cnt   <= '0;
                                state <= DUMP;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mrfm_iq_avg.sv
// tb_mrfm_iq_avg: self-checking bench for mrfm_iq_avg.
// Table-driven frames plus hand-written corner sequences, scoreboard checked.
module tb_mrfm_iq_avg;

    logic               clock = 1'b0;
    logic               reset;
    logic               enable;
    logic [6:0]         serial_addr;
    logic [31:0]        serial_data;
    logic               serial_strobe;
    logic               strobe_in;
    logic signed [15:0] i_in, q_in, ip_in, qp_in;
    logic signed [15:0] i_out, q_out, ip_out, qp_out;
    logic               strobe_out;
    logic [15:0]        debugbus;

    mrfm_iq_avg dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .serial_strobe (serial_strobe),
        .strobe_in     (strobe_in),
        .i_in          (i_in),
        .q_in          (q_in),
        .ip_in         (ip_in),
        .qp_in         (qp_in),
        .i_out         (i_out),
        .q_out         (q_out),
        .ip_out        (ip_out),
        .qp_out        (qp_out),
        .strobe_out    (strobe_out),
        .debugbus      (debugbus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int i, q, ip, qp;
        int due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int total = 0;
    int bad = 0;

    typedef struct {
        int k;
        int gap;
        int n;
        int i[4];
        int q[4];
        int ip[4];
        int qp[4];
        int ei, eq, eip, eqp;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (strobe_out === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got i_out=%0d, want no pulse (cycle %0d)",
                         i_out, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("latency", cyc, mon_e.due);
                chk("i_out", int'(i_out), mon_e.i);
                chk("q_out", int'(q_out), mon_e.q);
                chk("ip_out", int'(ip_out), mon_e.ip);
                chk("qp_out", int'(qp_out), mon_e.qp);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_len(input int k);
        serial_strobe = 1'b1;
        serial_addr   = 7'd70;
        serial_data   = 32'(k);
        tick();
        serial_strobe = 1'b0;
    endtask

    task automatic sample(input int i, input int q, input int ip, input int qp);
        strobe_in = 1'b1;
        i_in      = 16'(i);
        q_in      = 16'(q);
        ip_in     = 16'(ip);
        qp_in     = 16'(qp);
        tick();
        strobe_in = 1'b0;
    endtask

    // Call just before driving the last sample of a frame.
    task automatic expect4(input int i, input int q, input int ip, input int qp);
        exp_t e;
        e.i   = i;
        e.q   = q;
        e.ip  = ip;
        e.qp  = qp;
        e.due = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && sb.size() > 0; n++) tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending outputs, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_i"}, int'(i_out), 0);
        chk({tag, "_q"}, int'(q_out), 0);
        chk({tag, "_ip"}, int'(ip_out), 0);
        chk({tag, "_qp"}, int'(qp_out), 0);
        chk({tag, "_strobe"}, int'(strobe_out), 0);
        chk({tag, "_debug"}, int'(debugbus), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2, 3, 4, '{1, 2, 3, 4}, '{-1, -2, -3, -4},
                   '{0, 0, 0, 1}, '{5, 5, 5, 6}, 3, -2, 0, 5};
        tbl[1] = '{1, 1, 2, '{10, 20, 0, 0}, '{-3, -4, 0, 0},
                   '{32767, 32767, 0, 0}, '{-32768, -32768, 0, 0},
                   15, -3, 32767, -32768};
        tbl[2] = '{0, 2, 1, '{100, 0, 0, 0}, '{-5, 0, 0, 0},
                   '{7, 0, 0, 0}, '{-1, 0, 0, 0}, 100, -5, 7, -1};
        tbl[3] = '{2, 1, 4, '{1, 1, 1, 2}, '{-1, -1, -1, -2},
                   '{2, 2, 2, 3}, '{-2, -2, -2, -3}, 1, -1, 2, -2};

        reset         = 1'b1;
        enable        = 1'b1;
        serial_addr   = 7'd0;
        serial_data   = 32'd0;
        serial_strobe = 1'b0;
        strobe_in     = 1'b0;
        i_in          = '0;
        q_in          = '0;
        ip_in         = '0;
        qp_in         = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk_zero("reset");
        tick();
        tick();

        // Default length N=1, samples on consecutive cycles.
        expect4(100, 1, -1, 0);
        sample(100, 1, -1, 0);
        expect4(200, 2, -2, 0);
        sample(200, 2, -2, 0);
        expect4(-5, 3, -3, 0);
        sample(-5, 3, -3, 0);
        drain();

        for (int r = 0; r < 4; r++) begin
            set_len(tbl[r].k);
            for (int s = 0; s < tbl[r].n; s++) begin
                if (s == tbl[r].n - 1)
                    expect4(tbl[r].ei, tbl[r].eq, tbl[r].eip, tbl[r].eqp);
                sample(tbl[r].i[s], tbl[r].q[s], tbl[r].ip[s], tbl[r].qp[s]);
                repeat (tbl[r].gap - 1) tick();
            end
            drain();
        end

        // Full-scale frames at N=256.
        set_len(8);
        for (int s = 0; s < 256; s++) begin
            if (s == 255) expect4(32767, 32767, 32767, 32767);
            sample(32767, 32767, 32767, 32767);
        end
        for (int s = 0; s < 256; s++) begin
            if (s == 255) expect4(-32768, -32768, -32768, -32768);
            sample(-32768, -32768, -32768, -32768);
        end
        drain();

        // Out-of-range length clamps to 8.
        set_len(15);
`ifdef MRFM_IQ_AVG_DEBUG_EN
        chk("clamp_log2", int'(debugbus[12:9]), 8);
`else
        chk("debug_off", int'(debugbus), 0);
`endif

        // Abort at N=4 with a sample on the write cycle.
        set_len(2);
        sample(1, -1, 1, 1);
        sample(1, -1, 1, 1);
        serial_strobe = 1'b1;
        serial_addr   = 7'd70;
        serial_data   = 32'd1;
        strobe_in     = 1'b1;
        i_in          = 16'sd100;
        q_in          = 16'sd100;
        ip_in         = 16'sd100;
        qp_in         = 16'sd100;
        tick();
        serial_strobe = 1'b0;
        strobe_in     = 1'b0;
        sample(6, -6, 6, 6);
        expect4(7, -7, 7, 7);
        sample(8, -8, 8, 8);
        drain();

        // Back-to-back frames at N=2.
        sample(10, -10, 0, 100);
        expect4(15, -15, 1, 100);
        sample(20, -20, 1, 100);
        sample(30, -30, 2, 100);
        expect4(35, -35, 3, 100);
        sample(40, -40, 3, 100);
        drain();

        // Reset in the middle of an N=4 frame.
        set_len(2);
        repeat (3) sample(50, 50, 50, 50);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_zero("midreset");
        repeat (4) tick();
        set_len(2);
        repeat (3) sample(4, -4, 4, -4);
        expect4(4, -4, 4, -4);
        sample(4, -4, 4, -4);
        drain();

        // Enable dropped mid-frame: partial frame discarded, outputs held.
        repeat (2) sample(20, 20, 20, 20);
        enable = 1'b0;
        tick();
        sample(99, 99, 99, 99);
        repeat (3) tick();
        chk("hold_i", int'(i_out), 4);
        chk("hold_q", int'(q_out), -4);
        chk("hold_strobe", int'(strobe_out), 0);
        enable = 1'b1;
        tick();
        tick();
        repeat (3) sample(8, -8, 8, 8);
        expect4(9, -9, 9, 9);
        sample(12, -12, 12, 12);
        drain();

        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
